sipo_comma_align: RTL and testbench

// - PMA receive-side deserializer: the counterpart of the transmit serializer. Shifts in a 1-bit line,

---
 rtl/sipo_comma_align.sv | 144 ++++++++++++++
 tb/tb_sipo_comma_align.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_comma_align.sv
// Receive deserializer: shifts in a serial line, hunts for the K28.5 comma and locks 10-bit word
// boundaries through an UNSYNC/ACQUIRE/SYNC qualifier. Define SIPO_BOTH_COMMA_EN to accept both disparities.
module sipo_comma_align #(
  parameter int                LENGTH     = 10,
  parameter logic [LENGTH-1:0] COMMA_P    = 10'b0011111010,
  parameter logic [LENGTH-1:0] COMMA_N    = 10'b1100000101,
  parameter int                LOCK_COUNT = 3,
  parameter int                LOSS_COUNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_in,
  input  logic              s_valid,
  output logic [LENGTH-1:0] parallel_out,
  output logic              p_valid,
  output logic              comma_det,
  output logic              sync
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);
  localparam logic [GW-1:0] LOCK_CNT_W = GW'(LOCK_COUNT);
  localparam logic [BW-1:0] LOSS_CNT_W = BW'(LOSS_COUNT);
  localparam logic [3:0]    LAST_BIT   = 4'(LENGTH - 1);
`ifdef SIPO_BOTH_COMMA_EN
  localparam logic COMMA_N_EN = 1'b1;
`else
  localparam logic COMMA_N_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_UNSYNC,
    ST_ACQUIRE,
    ST_SYNC
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [GW-1:0]     r_good, w_good_nxt, w_good_inc;
  logic [BW-1:0]     r_bad, w_bad_nxt, w_bad_inc;
  logic [LENGTH-2:0] r_sr;
  logic [3:0]        r_bit_cnt;
  logic [LENGTH-1:0] r_parallel_out;
  logic              r_p_valid, r_comma_det, r_sync;
  logic [LENGTH-1:0] w_window;
  logic              w_is_comma, w_boundary, w_realign, w_emit;

  // Only the newest LENGTH-1 bits are stored; the incoming bit completes the window.
  assign w_window   = {r_sr, s_in};
  assign w_is_comma = s_valid & ((w_window == COMMA_P) | (COMMA_N_EN & (w_window == COMMA_N)));
  assign w_boundary = s_valid & (r_bit_cnt == LAST_BIT);
  assign w_emit     = (r_state == ST_SYNC) & w_boundary;
  assign w_good_inc = r_good + 1'b1;
  assign w_bad_inc  = r_bad + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_UNSYNC;
      r_good  <= '0;
      r_bad   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
      r_bad   <= w_bad_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_bad_nxt   = r_bad;
    w_realign   = 1'b0;
    case (r_state)
      ST_UNSYNC: begin
        if (w_is_comma) begin
          w_realign   = 1'b1;
          w_good_nxt  = GW'(1);
          w_state_nxt = (LOCK_COUNT == 1) ? ST_SYNC : ST_ACQUIRE;
        end
      end
      ST_ACQUIRE: begin
        if (w_boundary && w_is_comma) begin
          w_good_nxt = w_good_inc;
          if (w_good_inc == LOCK_CNT_W) w_state_nxt = ST_SYNC;
        end else if (w_boundary) begin
          w_good_nxt  = '0;
          w_state_nxt = ST_UNSYNC;
        end else if (w_is_comma) begin
          // A comma at a new phase restarts acquisition on that phase.
          w_realign  = 1'b1;
          w_good_nxt = GW'(1);
        end
      end
      ST_SYNC: begin
        if (w_boundary && w_is_comma) begin
          w_bad_nxt = '0;
        end else if (w_is_comma) begin
          w_bad_nxt = w_bad_inc;
          if (w_bad_inc == LOSS_CNT_W) begin
            w_bad_nxt   = '0;
            w_good_nxt  = '0;
            w_state_nxt = ST_UNSYNC;
          end
        end
      end
      default: begin
        w_good_nxt  = '0;
        w_bad_nxt   = '0;
        w_state_nxt = ST_UNSYNC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
    end else if (s_valid) begin
      r_sr <= w_window[LENGTH-2:0];
      if (w_realign || (r_bit_cnt == LAST_BIT)) r_bit_cnt <= '0;
      else                                      r_bit_cnt <= r_bit_cnt + 4'd1;
    end
  end

  // Output stage: words are emitted only while already locked, so the locking comma never appears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_parallel_out <= '0;
      r_p_valid      <= 1'b0;
      r_comma_det    <= 1'b0;
      r_sync         <= 1'b0;
    end else begin
      r_p_valid   <= w_emit;
      r_comma_det <= w_is_comma;
      r_sync      <= (w_state_nxt == ST_SYNC);
      if (w_emit) r_parallel_out <= w_window;
    end
  end

  assign parallel_out = r_parallel_out;
  assign p_valid      = r_p_valid;
  assign comma_det    = r_comma_det;
  assign sync         = r_sync;

endmodule

// File: tb/tb_sipo_comma_align.sv
// Bench for sipo_comma_align: directed lock/loss scenarios plus random traffic, all checked every
// cycle against a bit-count/phase reference model.
module tb_sipo_comma_align;

  localparam logic [9:0] CP   = 10'b0011111010;
  localparam logic [9:0] CN   = 10'b1100000101;
  localparam int         LOCK = 3;
  localparam int         LOSS = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_in = 1'b0;
  logic       s_valid = 1'b0;
  logic [9:0] parallel_out;
  logic       p_valid, comma_det, sync;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int pv_cnt = 0;
  int cd_cnt = 0;
  int cd_cyc[$];
  bit sync_seen = 1'b0;

  // Reference model: phase is the count of valid bits since the last realignment point.
  logic [9:0] m_po = '0;
  logic       m_pv = 1'b0, m_cd = 1'b0, m_sync = 1'b0;
  int         m_state = 0;  // 0 hunting, 1 acquiring, 2 locked
  int         m_good = 0, m_bad = 0, m_n = 0, m_anchor = 0;
  logic       mq[$];

  sipo_comma_align #(
    .LENGTH(10), .COMMA_P(CP), .COMMA_N(CN), .LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS)
  ) dut (
    .clk(clk), .reset(reset), .s_in(s_in), .s_valid(s_valid),
    .parallel_out(parallel_out), .p_valid(p_valid), .comma_det(comma_det), .sync(sync)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_po = '0; m_pv = 1'b0; m_cd = 1'b0; m_sync = 1'b0;
    m_state = 0; m_good = 0; m_bad = 0; m_n = 0; m_anchor = 0;
    mq.delete();
  endfunction

  function automatic logic [9:0] model_window(input logic b);
    logic [9:0] w;
    w = '0;
    w[0] = b;
    for (int i = 0; i < 9; i++)
      if (mq.size() > i) w[i+1] = mq[mq.size()-1-i];
    return w;
  endfunction

  function automatic void model_step(input logic b, input logic v);
    logic [9:0] w;
    bit comma, bnd;
    int n;
    if (!reset) begin
      model_reset();
      return;
    end
    m_pv = 1'b0;
    m_cd = 1'b0;
    if (v) begin
      w = model_window(b);
      comma = (w == CP);
`ifdef SIPO_BOTH_COMMA_EN
      comma = comma || (w == CN);
`endif
      n = m_n + 1;
      bnd = ((n - m_anchor) % 10) == 0;
      if (m_state == 2 && bnd) begin
        m_pv = 1'b1;
        m_po = w;
      end
      m_cd = comma;
      if (m_state == 0) begin
        if (comma) begin
          m_anchor = n; m_good = 1;
          m_state = (m_good >= LOCK) ? 2 : 1;
        end
      end else if (m_state == 1) begin
        if (comma && bnd) begin
          m_good++;
          if (m_good >= LOCK) m_state = 2;
        end else if (bnd) begin
          m_state = 0; m_good = 0;
        end else if (comma) begin
          m_anchor = n; m_good = 1;
        end
      end else begin
        if (comma && bnd) m_bad = 0;
        else if (comma) begin
          m_bad++;
          if (m_bad >= LOSS) begin
            m_state = 0; m_bad = 0; m_good = 0;
          end
        end
      end
      mq.push_back(b);
      if (mq.size() > 10) void'(mq.pop_front());
      m_n = n;
    end
    m_sync = (m_state == 2);
  endfunction

  task automatic step(input logic b, input logic v);
    s_in = b;
    s_valid = v;
    @(posedge clk);
    model_step(b, v);
    #1;
    cyc++;
    chk("comma_det", 32'(comma_det), 32'(m_cd));
    chk("p_valid", 32'(p_valid), 32'(m_pv));
    chk("parallel_out", 32'(parallel_out), 32'(m_po));
    chk("sync", 32'(sync), 32'(m_sync));
    if (p_valid) pv_cnt++;
    if (comma_det) begin
      cd_cnt++;
      cd_cyc.push_back(cyc);
    end
    if (sync) sync_seen = 1'b1;
  endtask

  task automatic send_word(input logic [9:0] w, input bit gaps);
    for (int i = 9; i >= 0; i--) begin
      step(w[i], 1'b1);
      if (gaps) step(1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic clr();
    pv_cnt = 0;
    cd_cnt = 0;
    cd_cyc.delete();
    sync_seen = 1'b0;
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_async_po", 32'(parallel_out), 32'h0);
    chk("rst_async_sync", 32'(sync), 32'h0);
    chk("rst_async_strobes", 32'({p_valid, comma_det}), 32'h0);
    for (int i = 0; i < ncyc; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    #3 reset = 1'b1;
  endtask

  task automatic lock3();
    repeat (3) send_word(CP, 1'b0);
  endtask

  initial begin
    // Reset with random traffic on the line
    clr();
    do_reset(12);
    chk("reset_strobes_seen", 32'(pv_cnt + cd_cnt), 32'd0);
    chk("reset_sync_seen", 32'(sync_seen), 32'd0);

    // Lock on three aligned commas, then one data word
    clr();
    lock3();
    chk("lock_cd_cnt", 32'(cd_cnt), 32'd3);
    if (cd_cyc.size() == 3) begin
      chk("lock_cd_gap1", 32'(cd_cyc[1] - cd_cyc[0]), 32'd10);
      chk("lock_cd_gap2", 32'(cd_cyc[2] - cd_cyc[1]), 32'd10);
    end
    chk("lock_sync", 32'(sync), 32'd1);
    chk("lock_no_pv", 32'(pv_cnt), 32'd0);
    clr();
    send_word(10'b1010101111, 1'b0);
    chk("word_pv_cnt", 32'(pv_cnt), 32'd1);
    chk("word_data", 32'(parallel_out), 32'h2AF);
    idle(3);
    chk("word_hold", 32'(parallel_out), 32'h2AF);

    // Words with idle cycles interleaved
    clr();
    send_word(10'h2AF, 1'b1);
    chk("gap_pv_cnt", 32'(pv_cnt), 32'd1);
    chk("gap_data", 32'(parallel_out), 32'h2AF);
    clr();
    send_word(10'h155, 1'b1);
    chk("gap2_pv_cnt", 32'(pv_cnt), 32'd1);
    chk("gap2_data", 32'(parallel_out), 32'h155);

    // Slip by one bit: four misaligned commas drop sync
    step(1'b0, 1'b1);
    repeat (3) send_word(CP, 1'b0);
    chk("mis3_sync", 32'(sync), 32'd1);
    send_word(CP, 1'b0);
    chk("mis4_sync_drop", 32'(sync), 32'd0);
    clr();
    repeat (20) step(1'b0, 1'b1);
    chk("mis_no_pv", 32'(pv_cnt), 32'd0);

    // Three misaligned then one aligned comma keeps sync and clears the loss count
    do_reset(3);
    lock3();
    step(1'b0, 1'b1);
    repeat (3) send_word(CP, 1'b0);
    repeat (9) step(1'b0, 1'b1);
    send_word(CP, 1'b0);
    chk("realigned_sync", 32'(sync), 32'd1);
    step(1'b0, 1'b1);
    repeat (3) send_word(CP, 1'b0);
    chk("bad_cleared_sync", 32'(sync), 32'd1);

    // Acquisition aborted by a data word at the boundary
    do_reset(3);
    clr();
    send_word(CP, 1'b0);
    send_word(CP, 1'b0);
    send_word(10'h155, 1'b0);
    chk("abort_sync_seen", 32'(sync_seen), 32'd0);
    send_word(CP, 1'b0);
    send_word(CP, 1'b0);
    chk("abort_reacq_sync", 32'(sync), 32'd0);
    send_word(CP, 1'b0);
    chk("abort_relock_sync", 32'(sync), 32'd1);

    // Reset in the middle of a word
    do_reset(2);
    lock3();
    for (int i = 9; i >= 5; i--) step(1'(10'h2AF >> i), 1'b1);
    do_reset(4);
    chk("midrst_po", 32'(parallel_out), 32'h0);
    chk("midrst_sync", 32'(sync), 32'd0);
    send_word(CP, 1'b0);
    send_word(CP, 1'b0);
    chk("midrst_two_commas", 32'(sync), 32'd0);
    send_word(CP, 1'b0);
    chk("midrst_relock", 32'(sync), 32'd1);

    // Negative-disparity commas
    do_reset(2);
    clr();
    repeat (3) send_word(CN, 1'b0);
`ifdef SIPO_BOTH_COMMA_EN
    chk("commaN_sync", 32'(sync), 32'd1);
    chk("commaN_cd_cnt", 32'(cd_cnt), 32'd3);
`else
    chk("commaN_sync", 32'(sync), 32'd0);
    chk("commaN_cd_cnt", 32'(cd_cnt), 32'd0);
`endif

    // Random traffic against the model
    do_reset(2);
    for (int it = 0; it < 500; it++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 7)       send_word(CP, 1'b0);
      else if (r < 8)  send_word(CN, 1'b0);
      else if (r < 12) send_word(10'($urandom), 1'b0);
      else if (r < 14) send_word(10'($urandom), 1'b1);
      else if (r < 17) repeat ($urandom_range(1, 3)) step(1'($urandom_range(0, 1)), 1'b1);
      else if (r < 19) idle(int'($urandom_range(1, 4)));
      else             do_reset(int'($urandom_range(1, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
